vga_sprite_renderer: RTL and testbench
======================================

Name: vga_sprite_renderer

Overview:
Parametrised VGA timing generator and layered sprite renderer for the game display path. It generalises the fixed 640x480 single-ship controller: configurable timing, NUM_SPRITES independently positioned and coloured sprites, a registered pixel pipeline and frame-synchronous double-buffered sprite state. It sits between the game-state RAM readout and the VGA DAC (red/green/blue/blankN/vgaClk/hsync/vsync).

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
COORD_W, 10, width of hcount/vcount and sprite coordinates; H_TOTAL and V_TOTAL must be < 2^COORD_W
NUM_SPRITES, 4, sprite slots; index 0 has highest priority
SPRITE_SIZE, 16, square sprite edge length (pixels)
CLK_DIV, 2, clk cycles per pixel; power of two, >= 2
BG_COLOR, 24'h0C0AB5, background RGB
MODE_COLOR_START / _DEAD / _WON, 24'hFFFFFF / 24'hFF0000 / 24'h00FF00, full-screen colours

Ports:
clk  in  1  system clock
rstN  in  1  asynchronous active-low reset
wrEn  in  1  write strobe for one sprite slot
wrIdx  in  clog2(NUM_SPRITES)  slot to write
wrX  in  COORD_W  sprite left edge, display coordinates
wrY  in  COORD_W  sprite top edge, display coordinates
wrColor  in  24  sprite RGB {r,g,b}
wrVisible  in  1  sprite enable
modeIn  in  2  0 = play, 1 = start screen, 2 = dead, 3 = won
red, green, blue  out  8 each  pixel colour
hsync, vsync  out  1 each  active-low sync
blankN  out  1  high in the visible region
vgaClk  out  1  pixel clock to the DAC
frameStart  out  1  one-clk pulse at the frame commit
hPos, vPos  out  COORD_W each  current counters (debug/feedback)

Behaviour:
- Reset (asynchronous, rstN=0): divider, hcount and vcount = 0; shadow and active sprite banks cleared with visible=0; active mode = 0; red/green/blue = 0; blankN = 0; hsync = vsync = 1; vgaClk = 0; frameStart = 0. Deasserting reset mid-frame restarts at pixel (0,0).
- Divider counts 0..CLK_DIV-1; tick when divider == CLK_DIV-1; vgaClk = (divider >= CLK_DIV/2). Outputs update only on tick edges, which coincide with vgaClk falling.
- Counter order per line: display [0,H_DISPLAY), front porch, sync, back porch; H_TOTAL = sum of the four. On tick, hcount wraps at H_TOTAL-1 to 0 and advances vcount; vcount wraps at V_TOTAL-1 to 0.
- Sync regions: hsync low for H_DISPLAY+H_FRONT <= hcount < H_DISPLAY+H_FRONT+H_SYNC; vsync uses the same form.
- Writes: wrEn updates shadow slot wrIdx on any clk edge, independent of tick. An out-of-range wrIdx is ignored.
- Commit: on the tick where hcount==H_TOTAL-1 and vcount==V_TOTAL-1, shadow is copied to active, modeIn is sampled into the active mode, and frameStart pulses for that one clk.
  - If a write lands on the commit clk, the pre-write shadow is committed. The new value appears in the following frame.
  - Mid-frame writes never tear the image.
- Hit test per sprite: visible && hcount >= X && hcount < X+SPRITE_SIZE && vcount >= Y && vcount < Y+SPRITE_SIZE. Compute at COORD_W+1 bits so there is no wrap; sprites at the right or bottom edge are clipped.
- Colour priority:
  - Mode != 0 gives the corresponding mode colour.
  - Otherwise, the lowest-index hit sprite's colour.
  - Otherwise, BG_COLOR.
  - Outside the display region, colour = 0.
- Latency: colour, blankN, hsync and vsync are registered together, so they lag the counters by exactly one pixel tick and stay mutually aligned. hPos/vPos are unregistered counters.

Optional Feature:
SPRITE_COLLISION_EN: adds output collision [NUM_SPRITES-1:0].
- A per-frame sticky bit i is set when sprite i and any other sprite both hit the same displayed pixel.
- The sticky set is copied to collision at commit, then cleared.
- Without the macro, collision does not exist and no compare logic is built.

Test Plan:
- Reset, then run 2 frames at defaults -> 800*525 ticks per frame; hsync low for exactly 96 ticks per line; vsync low for 2 lines; blankN high for 640x480 pixels per frame; vgaClk period = 2 clk.
- Write slot 0 X=100, Y=50, color=24'hAF0F78, visible, then wait for commit -> pixels (100..115, 50..65) = AF0F78 one tick after the counters; pixel (116,50) = BG_COLOR.
- Overlap slot 0 at (200,200) red and slot 1 at (208,208) green -> pixel (210,210) red; pixel (220,220) green; with SPRITE_COLLISION_EN, collision = 4'b0011 after the next commit.
- Write slot 2 at X=630 mid-frame -> current frame unchanged; next frame shows columns 630..639 only, with no wrap to column 0.
- Set modeIn=2 mid-frame -> screen changes to FF0000 only after frameStart; write coincident with the commit clk -> new value is deferred one frame.
- Assert rstN low mid-line -> outputs return to reset values immediately; after release, hPos=0, vPos=0 and timing restarts cleanly.

Source files
------------

// File: rtl/vga_sprite_renderer_if.sv
// Sprite slot write bus between the game-state readout and the renderer's shadow bank.
interface vga_sprite_renderer_if #(
    parameter int COORD_W = 10,
    parameter int IDX_W   = 2
);
    // wrEn is a valid strobe with no ready: the renderer accepts every strobed write on that clk edge.
    logic               wrEn;
    logic [IDX_W-1:0]   wrIdx;
    logic [COORD_W-1:0] wrX;
    logic [COORD_W-1:0] wrY;
    logic [23:0]        wrColor;
    logic               wrVisible;

    modport master (output wrEn, wrIdx, wrX, wrY, wrColor, wrVisible);
    modport slave  (input  wrEn, wrIdx, wrX, wrY, wrColor, wrVisible);
endinterface

// File: rtl/vga_sprite_renderer.sv
// VGA timing generator with a layered, frame-synchronous, double-buffered sprite renderer.
// Optional macro SPRITE_COLLISION_EN adds a per-frame sprite collision output.
module vga_sprite_renderer #(
    parameter int          H_DISPLAY        = 640,
    parameter int          H_FRONT          = 16,
    parameter int          H_SYNC           = 96,
    parameter int          H_BACK           = 48,
    parameter int          V_DISPLAY        = 480,
    parameter int          V_FRONT          = 10,
    parameter int          V_SYNC           = 2,
    parameter int          V_BACK           = 33,
    parameter int          COORD_W          = 10,
    parameter int          NUM_SPRITES      = 4,
    parameter int          SPRITE_SIZE      = 16,
    parameter int          CLK_DIV          = 2,
    parameter logic [23:0] BG_COLOR         = 24'h0C0AB5,
    parameter logic [23:0] MODE_COLOR_START = 24'hFFFFFF,
    parameter logic [23:0] MODE_COLOR_DEAD  = 24'hFF0000,
    parameter logic [23:0] MODE_COLOR_WON   = 24'h00FF00
) (
    input  logic                   clk,
    input  logic                   rstN,
    vga_sprite_renderer_if.slave   wr,
    input  logic [1:0]             modeIn,
    output logic [7:0]             red,
    output logic [7:0]             green,
    output logic [7:0]             blue,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   blankN,
    output logic                   vgaClk,
    output logic                   frameStart,
    output logic [COORD_W-1:0]     hPos,
    output logic [COORD_W-1:0]     vPos
`ifdef SPRITE_COLLISION_EN
    ,
    output logic [NUM_SPRITES-1:0] collision
`endif
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_DISP   = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_DISP   = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [COORD_W:0]   SIZE_EXT = (COORD_W + 1)'(SPRITE_SIZE);

    logic [DIV_W-1:0]   div_q;
    logic [COORD_W-1:0] hcount_q;
    logic [COORD_W-1:0] vcount_q;
    logic               tick;
    logic               commit;
    logic               idx_ok;

    logic [COORD_W-1:0] sh_x     [NUM_SPRITES];
    logic [COORD_W-1:0] sh_y     [NUM_SPRITES];
    logic [23:0]        sh_color [NUM_SPRITES];
    logic               sh_vis   [NUM_SPRITES];
    logic [COORD_W-1:0] act_x    [NUM_SPRITES];
    logic [COORD_W-1:0] act_y    [NUM_SPRITES];
    logic [23:0]        act_color[NUM_SPRITES];
    logic               act_vis  [NUM_SPRITES];
    logic [1:0]         mode_q;

    logic [NUM_SPRITES-1:0] hit;
    logic                   in_display;
    logic [23:0]            sprite_rgb;
    logic [23:0]            pix_rgb;
    logic [23:0]            rgb_q;

    assign tick   = (div_q == DIV_LAST);
    assign commit = tick && (hcount_q == H_LAST) && (vcount_q == V_LAST);
    assign idx_ok = (32'(wr.wrIdx) < NUM_SPRITES);
    assign vgaClk = (div_q >= DIV_HALF);
    assign hPos   = hcount_q;
    assign vPos   = vcount_q;
    assign red    = rgb_q[23:16];
    assign green  = rgb_q[15:8];
    assign blue   = rgb_q[7:0];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else if (tick) begin
            if (hcount_q == H_LAST) begin
                hcount_q <= '0;
                vcount_q <= (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_q <= hcount_q + 1'b1;
            end
        end
    end

    // Writes go to the shadow bank only; the picture reads the active bank, so nothing tears.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x[i]     <= '0;
                sh_y[i]     <= '0;
                sh_color[i] <= '0;
                sh_vis[i]   <= 1'b0;
            end
        end else if (wr.wrEn && idx_ok) begin
            sh_x[wr.wrIdx]     <= wr.wrX;
            sh_y[wr.wrIdx]     <= wr.wrY;
            sh_color[wr.wrIdx] <= wr.wrColor;
            sh_vis[wr.wrIdx]   <= wr.wrVisible;
        end
    end

    // Non-blocking copy takes the pre-write shadow when a write shares the commit edge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                act_x[i]     <= '0;
                act_y[i]     <= '0;
                act_color[i] <= '0;
                act_vis[i]   <= 1'b0;
            end
            mode_q     <= 2'd0;
            frameStart <= 1'b0;
        end else begin
            frameStart <= commit;
            if (commit) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    act_x[i]     <= sh_x[i];
                    act_y[i]     <= sh_y[i];
                    act_color[i] <= sh_color[i];
                    act_vis[i]   <= sh_vis[i];
                end
                mode_q <= modeIn;
            end
        end
    end

    // One extra bit keeps X+SPRITE_SIZE from wrapping, so edge sprites clip instead.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit[i] = act_vis[i]
                  && ({1'b0, hcount_q} >= {1'b0, act_x[i]})
                  && ({1'b0, hcount_q} <  ({1'b0, act_x[i]} + SIZE_EXT))
                  && ({1'b0, vcount_q} >= {1'b0, act_y[i]})
                  && ({1'b0, vcount_q} <  ({1'b0, act_y[i]} + SIZE_EXT));
        end
    end

    always_comb begin
        in_display = (hcount_q < H_DISP) && (vcount_q < V_DISP);
        sprite_rgb = BG_COLOR;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sprite_rgb = act_color[i];
            end
        end
        case (mode_q)
            2'd1:    pix_rgb = MODE_COLOR_START;
            2'd2:    pix_rgb = MODE_COLOR_DEAD;
            2'd3:    pix_rgb = MODE_COLOR_WON;
            default: pix_rgb = sprite_rgb;
        endcase
        if (!in_display) begin
            pix_rgb = '0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rgb_q  <= '0;
            blankN <= 1'b0;
            hsync  <= 1'b1;
            vsync  <= 1'b1;
        end else if (tick) begin
            rgb_q  <= pix_rgb;
            blankN <= in_display;
            hsync  <= !((hcount_q >= HS_START) && (hcount_q < HS_END));
            vsync  <= !((vcount_q >= VS_START) && (vcount_q < VS_END));
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic [NUM_SPRITES-1:0] pair_hit;
    logic [NUM_SPRITES-1:0] sticky_q;

    always_comb begin
        pair_hit = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            pair_hit[i] = hit[i] && ((hit & ~(NUM_SPRITES'(1) << i)) != '0);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sticky_q  <= '0;
            collision <= '0;
        end else if (commit) begin
            collision <= sticky_q;
            sticky_q  <= '0;
        end else if (tick && in_display) begin
            sticky_q <= sticky_q | pair_hit;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Directed bench for vga_sprite_renderer on a shrunken 56x37 raster so several frames stay short.
module tb_vga_sprite_renderer;
    localparam int HD = 40, HF = 4, HS = 6, HB = 6, HT = 56;
    localparam int VD = 30, VF = 2, VS = 2, VB = 3, VT = 37;
    localparam int CW = 10, NS = 4, SZ = 8, CD = 2;
    localparam logic [23:0] BG = 24'h0C0AB5;
    localparam int BOUND = HT * VT * CD + 100;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic [1:0]    modeIn = 2'd0;
    logic [7:0]    red, green, blue;
    logic          hsync, vsync, blankN, vgaClk, frameStart;
    logic [CW-1:0] hPos, vPos;
`ifdef SPRITE_COLLISION_EN
    logic [NS-1:0] collision;
`endif

    vga_sprite_renderer_if #(.COORD_W(CW), .IDX_W(2)) bus();

    vga_sprite_renderer #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .COORD_W(CW), .NUM_SPRITES(NS), .SPRITE_SIZE(SZ), .CLK_DIV(CD)
    ) dut (
        .clk(clk), .rstN(rstN), .wr(bus.slave), .modeIn(modeIn),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .blankN(blankN), .vgaClk(vgaClk),
        .frameStart(frameStart), .hPos(hPos), .vPos(vPos)
`ifdef SPRITE_COLLISION_EN
        , .collision(collision)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- capture monitor ----------------
    int mh = 0, mv = 0, tick_cnt = 0, pos_err = 0;
    logic [23:0] cap_rgb [VT][HT];
    logic        cap_bn  [VT][HT];
    logic        cap_hs  [VT][HT];
    logic        cap_vs  [VT][HT];

    // Outputs after a tick describe the pixel the bench's own counters held before that tick.
    always @(negedge vgaClk or negedge rstN) begin
        if (!rstN) begin
            mh = 0;
            mv = 0;
        end else begin
            #1;
            if (rstN) begin
                cap_rgb[mv][mh] = {red, green, blue};
                cap_bn[mv][mh]  = blankN;
                cap_hs[mv][mh]  = hsync;
                cap_vs[mv][mh]  = vsync;
                tick_cnt++;
                if (mh == HT - 1) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end else begin
                    mh++;
                end
                if (hPos !== CW'(mh) || vPos !== CW'(mv)) pos_err++;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          frame;
        int          x;
        int          y;
        logic [23:0] rgb;
        logic        bn;
    } probe_t;

    probe_t      probes[$];
    logic [24:0] exp_q[$];
    int          chk_total = 0, chk_pass = 0;
    int          tick_base = 0, ticks_last = 0, pos_base = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_total++;
        if (act === exp) chk_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add_probe(input int f, input int x, input int y, input logic [23:0] rgb, input logic bn);
        probes.push_back('{f, x, y, rgb, bn});
    endtask

    task automatic check_frame(input int f);
        logic [24:0] act;
        logic [24:0] exp;
        foreach (probes[k]) begin
            if (probes[k].frame == f) begin
                exp_q.push_back({probes[k].bn, probes[k].rgb});
                act = {cap_bn[probes[k].y][probes[k].x], cap_rgb[probes[k].y][probes[k].x]};
                exp = exp_q.pop_front();
                check($sformatf("f%0d_px(%0d,%0d)", f, probes[k].x, probes[k].y), 32'(act), 32'(exp));
            end
        end
    endtask

    task automatic check_timing(input string tag);
        int bn_cnt = 0, vs_cnt = 0, hs_good = 0, low;
        for (int v = 0; v < VT; v++) begin
            low = 0;
            for (int h = 0; h < HT; h++) begin
                bn_cnt += int'(cap_bn[v][h]);
                vs_cnt += int'(!cap_vs[v][h]);
                low    += int'(!cap_hs[v][h]);
            end
            if (low == HS && !cap_hs[v][HD+HF] && !cap_hs[v][HD+HF+HS-1]
                && cap_hs[v][HD+HF-1] && cap_hs[v][HD+HF+HS]) hs_good++;
        end
        check({tag, "_frame_ticks"}, 32'(ticks_last), 32'(HT * VT));
        check({tag, "_blank_hi_count"}, 32'(bn_cnt), 32'(HD * VD));
        check({tag, "_hsync_lines_ok"}, 32'(hs_good), 32'(VT));
        check({tag, "_vsync_low_count"}, 32'(vs_cnt), 32'(VS * HT));
        check({tag, "_vsync_edges"},
              32'({cap_vs[VD+VF-1][HT-1], cap_vs[VD+VF][0], cap_vs[VD+VF+VS-1][HT-1], cap_vs[VD+VF+VS][0]}),
              32'(4'b1001));
        check({tag, "_pos_track_err"}, 32'(pos_err - pos_base), 32'(0));
        pos_base = pos_err;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_slot(input int idx, input int x, input int y, input logic [23:0] c, input logic vis);
        bus.wrIdx     = 2'(idx);
        bus.wrX       = CW'(x);
        bus.wrY       = CW'(y);
        bus.wrColor   = c;
        bus.wrVisible = vis;
        bus.wrEn      = 1'b1;
    endtask

    task automatic write_slot(input int idx, input int x, input int y, input logic [23:0] c, input logic vis);
        @(negedge clk);
        drive_slot(idx, x, y, c, vis);
        @(negedge clk);
        bus.wrEn = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (frameStart === 1'b1) break;
        end
        check({name, "_frameStart_seen"}, 32'(frameStart), 32'(1));
        ticks_last = tick_cnt - tick_base;
        tick_base  = tick_cnt;
    endtask

    task automatic wait_model(input int h, input int v, input string name);
        int found = 0;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if ((h < 0 || mh == h) && mv >= v) begin
                found = 1;
                break;
            end
        end
        if (found == 0) check({name, "_timeout"}, 32'(found), 32'(1));
    endtask

    // Holds wrEn high exactly on the commit edge: one tick after the model reaches the last pixel.
    task automatic commit_write(input int idx, input int x, input int y, input logic [23:0] c);
        int found = 0;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (mh == HT - 1 && mv == VT - 1) begin
                found = 1;
                break;
            end
        end
        if (found == 0) check("commit_write_timeout", 32'(found), 32'(1));
        @(posedge clk);
        @(negedge clk);
        drive_slot(idx, x, y, c, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.wrEn = 1'b0;
        check("commit_write_frameStart", 32'(frameStart), 32'(1));
        ticks_last = tick_cnt - tick_base;
        tick_base  = tick_cnt;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"}, 32'({red, green, blue}), 32'(0));
        check({tag, "_blankN"}, 32'(blankN), 32'(0));
        check({tag, "_hsync"}, 32'(hsync), 32'(1));
        check({tag, "_vsync"}, 32'(vsync), 32'(1));
        check({tag, "_vgaClk"}, 32'(vgaClk), 32'(0));
        check({tag, "_frameStart"}, 32'(frameStart), 32'(0));
        check({tag, "_hPos"}, 32'(hPos), 32'(0));
        check({tag, "_vPos"}, 32'(vPos), 32'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] pat;
        bus.wrEn = 1'b0; bus.wrIdx = '0; bus.wrX = '0; bus.wrY = '0;
        bus.wrColor = '0; bus.wrVisible = 1'b0;

        add_probe(0, 0, 0, BG, 1);          add_probe(0, 39, 29, BG, 1);
        add_probe(0, 10, 5, BG, 1);         add_probe(0, 40, 0, 24'h0, 0);
        add_probe(0, 0, 30, 24'h0, 0);      add_probe(0, 55, 36, 24'h0, 0);
        add_probe(1, 10, 5, BG, 1);         add_probe(1, 17, 12, BG, 1);
        add_probe(2, 10, 5, 24'hAF0F78, 1); add_probe(2, 17, 12, 24'hAF0F78, 1);
        add_probe(2, 18, 5, BG, 1);         add_probe(2, 17, 13, BG, 1);
        add_probe(2, 9, 5, BG, 1);          add_probe(2, 10, 4, BG, 1);
        add_probe(3, 25, 19, 24'hFF0000, 1); add_probe(3, 21, 15, 24'hFF0000, 1);
        add_probe(3, 29, 23, 24'h00FF00, 1); add_probe(3, 31, 25, 24'h00FF00, 1);
        add_probe(3, 32, 25, BG, 1);        add_probe(3, 10, 5, BG, 1);
        add_probe(3, 37, 2, BG, 1);
        add_probe(4, 36, 0, 24'h0000FF, 1); add_probe(4, 39, 7, 24'h0000FF, 1);
        add_probe(4, 36, 8, BG, 1);         add_probe(4, 35, 0, BG, 1);
        add_probe(4, 0, 0, BG, 1);          add_probe(4, 3, 0, BG, 1);
        add_probe(4, 40, 0, 24'h0, 0);      add_probe(4, 25, 19, 24'hFF0000, 1);
        add_probe(5, 0, 0, 24'hFF0000, 1);  add_probe(5, 25, 19, 24'hFF0000, 1);
        add_probe(5, 39, 29, 24'hFF0000, 1); add_probe(5, 40, 5, 24'h0, 0);
        add_probe(6, 0, 20, BG, 1);         add_probe(6, 25, 19, 24'hFF0000, 1);
        add_probe(6, 36, 0, 24'h0000FF, 1);
        add_probe(7, 0, 20, 24'h123456, 1); add_probe(7, 7, 27, 24'h123456, 1);
        add_probe(7, 8, 20, BG, 1);         add_probe(7, 25, 19, 24'hFF0000, 1);
        add_probe(8, 25, 19, BG, 1);        add_probe(8, 0, 20, BG, 1);
        add_probe(8, 36, 0, BG, 1);         add_probe(8, 0, 0, BG, 1);
        add_probe(8, 40, 0, 24'h0, 0);

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        tick_base = tick_cnt;
        pos_base  = pos_err;
        rstN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pat[i] = vgaClk;
        end
        check("vgaClk_pattern", 32'(pat), 32'(8'b0101_0101));

        wait_frame("pulse1");
        check_timing("frame0");
        check_frame(0);
        write_slot(0, 10, 5, 24'hAF0F78, 1'b1);

        wait_frame("pulse2");
        check_frame(1);
        write_slot(0, 20, 14, 24'hFF0000, 1'b1);
        write_slot(1, 24, 18, 24'h00FF00, 1'b1);

        wait_frame("pulse3");
        check_frame(2);
        wait_model(-1, 10, "line10_a");
        write_slot(2, 36, 0, 24'h0000FF, 1'b1);

        wait_frame("pulse4");
        check_frame(3);
`ifdef SPRITE_COLLISION_EN
        check("collision", 32'(collision), 32'(4'b0011));
`endif
        wait_model(-1, 10, "line10_b");
        modeIn = 2'd2;

        wait_frame("pulse5");
        check_frame(4);
        modeIn = 2'd0;
        commit_write(3, 0, 20, 24'h123456);
        check_frame(5);

        wait_frame("pulse7");
        check_frame(6);
        wait_frame("pulse8");
        check_frame(7);

        wait_model(20, 5, "midline");
        @(negedge clk);
        rstN = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        tick_base = tick_cnt;
        pos_base  = pos_err;
        rstN = 1'b1;
        @(negedge clk);
        check("post_rst_hPos", 32'(hPos), 32'(0));
        check("post_rst_vPos", 32'(vPos), 32'(0));

        wait_frame("pulse9");
        check_timing("frame8");
        check_frame(8);

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end
endmodule
